// File: rtl/hash_out_buf.sv
// hash_out_buf: buffers a digest byte stream and drains it to a host.
// Define HASH_OUT_BUF_CRC_EN to append a CRC-8 trailer byte per record.
module hash_out_buf (
    input  logic       clk,
    input  logic       nreset,
    input  logic [5:0] nn_i,
    input  logic       h_v_i,
    input  logic [7:0] h_i,
    input  logic       rd_i,
    input  logic       clr_i,
    output logic       out_v_o,
    output logic [7:0] out_o,
    output logic       last_o,
    output logic       busy_o,
    output logic       ovf_o
);

`ifdef HASH_OUT_BUF_CRC_EN
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, CRC} state_t;
`else
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
`endif

    state_t     state, state_nx;
    logic [7:0] mem [32];
    logic [5:0] wr_cnt, rd_cnt, n_q, n_eff;
    logic       ovf_q;
    logic       rd_last, pop, final_pop, start, cap_wr, ovf_set;

    assign n_eff   = (nn_i == 6'd0 || nn_i > 6'd32) ? 6'd32 : nn_i;
    assign pop     = rd_i && out_v_o;
    assign rd_last = (rd_cnt == n_q - 6'd1);

`ifdef HASH_OUT_BUF_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8(input logic [7:0] c,
                                        input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    assign final_pop = pop && (state == CRC);
`else
    assign final_pop = pop && (state == DRAIN) && rd_last;
`endif

    // A byte arriving on the final pop opens the next record.
    assign start   = h_v_i && (state == IDLE || final_pop);
    assign cap_wr  = h_v_i && (state == CAPTURE);
    assign ovf_set = h_v_i && out_v_o && !final_pop;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            CAPTURE: if (h_v_i && wr_cnt == n_q - 6'd1) state_nx = DRAIN;
`ifdef HASH_OUT_BUF_CRC_EN
            DRAIN:   if (pop && rd_last) state_nx = CRC;
            CRC:     if (final_pop) state_nx = IDLE;
`else
            DRAIN:   if (final_pop) state_nx = IDLE;
`endif
            default: ;
        endcase
        if (start) state_nx = (n_eff == 6'd1) ? DRAIN : CAPTURE;
    end

    always_comb begin
        out_v_o = 1'b0;
        out_o   = 8'h00;
        last_o  = 1'b0;
        case (state)
            DRAIN: begin
                out_v_o = 1'b1;
                out_o   = mem[rd_cnt[4:0]];
`ifndef HASH_OUT_BUF_CRC_EN
                last_o  = rd_last;
`endif
            end
`ifdef HASH_OUT_BUF_CRC_EN
            CRC: begin
                out_v_o = 1'b1;
                out_o   = crc_q;
                last_o  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy_o = (state != IDLE);
    assign ovf_o  = ovf_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_cnt <= 6'd0;
            rd_cnt <= 6'd0;
            n_q    <= 6'd0;
        end else if (start) begin
            wr_cnt <= 6'd1;
            rd_cnt <= 6'd0;
            n_q    <= n_eff;
        end else if (final_pop) begin
            wr_cnt <= 6'd0;
            rd_cnt <= 6'd0;
        end else if (cap_wr) begin
            wr_cnt <= wr_cnt + 6'd1;
        end else if (pop) begin
            rd_cnt <= rd_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (start)       mem[0] <= h_i;
        else if (cap_wr) mem[wr_cnt[4:0]] <= h_i;
    end

`ifdef HASH_OUT_BUF_CRC_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)        crc_q <= 8'h00;
        else if (final_pop) crc_q <= 8'h00;
        else if (pop)       crc_q <= crc8(crc_q, out_o);
    end
`endif

    // Set wins over clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)      ovf_q <= 1'b0;
        else if (ovf_set) ovf_q <= 1'b1;
        else if (clr_i)   ovf_q <= 1'b0;
    end

endmodule

// File: tb/tb_hash_out_buf.sv
// Directed bench for hash_out_buf; inputs driven and outputs sampled
// on the falling clock edge.
module tb_hash_out_buf;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [5:0] nn_i = 6'd0;
    logic       h_v_i = 1'b0;
    logic [7:0] h_i = 8'h00;
    logic       rd_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       out_v_o, last_o, busy_o, ovf_o;
    logic [7:0] out_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_b [32];

    hash_out_buf dut (
        .clk     (clk),
        .nreset  (nreset),
        .nn_i    (nn_i),
        .h_v_i   (h_v_i),
        .h_i     (h_i),
        .rd_i    (rd_i),
        .clr_i   (clr_i),
        .out_v_o (out_v_o),
        .out_o   (out_o),
        .last_o  (last_o),
        .busy_o  (busy_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(input logic [7:0] c,
                                           input logic [7:0] d);
        logic fb;
        for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ d[b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic send(input logic [7:0] b);
        h_v_i = 1'b1;
        h_i   = b;
        @(negedge clk);
        h_v_i = 1'b0;
    endtask

    task automatic pop_all(input int n);
        logic [7:0] c = 8'h00;
        rd_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("pop_v", out_v_o, 1);
            chk("pop_data", out_o, exp_b[i]);
`ifdef HASH_OUT_BUF_CRC_EN
            chk("pop_last", last_o, 0);
`else
            chk("pop_last", last_o, (i == n - 1));
`endif
            c = crc_ref(c, exp_b[i]);
            @(negedge clk);
        end
`ifdef HASH_OUT_BUF_CRC_EN
        chk("pop_crc", out_o, c);
        chk("pop_crc_last", last_o, 1);
        @(negedge clk);
`endif
        rd_i = 1'b0;
        chk("pop_idle_busy", busy_o, 0);
        chk("pop_idle_v", out_v_o, 0);
        chk("pop_idle_out", out_o, 0);
    endtask

    initial begin
        #1;
        chk("rst_v", out_v_o, 0);
        chk("rst_out", out_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", ovf_o, 0);
        @(negedge clk);
        nreset = 1'b1;

        // 32 back-to-back bytes, rd_i held high throughout
        nn_i = 6'd32;
        rd_i = 1'b1;
        for (int i = 0; i < 31; i++) send(8'(i));
        chk("a_pre_v", out_v_o, 0);
        chk("a_pre_busy", busy_o, 1);
        send(8'h1F);
        chk("a_v_rise", out_v_o, 1);
        for (int i = 0; i < 32; i++) exp_b[i] = 8'(i);
        pop_all(32);

        // gapped capture then a 5-cycle hold in DRAIN
        nn_i = 6'd4;
        exp_b[0] = 8'h10; exp_b[1] = 8'h20;
        exp_b[2] = 8'h30; exp_b[3] = 8'h40;
        for (int i = 0; i < 4; i++) begin
            send(exp_b[i]);
            if (i < 3) chk("b_gap_v", out_v_o, 0);
            @(negedge clk);
        end
        repeat (5) begin
            chk("b_hold_v", out_v_o, 1);
            chk("b_hold_data", out_o, 8'h10);
            chk("b_hold_last", last_o, 0);
            @(negedge clk);
        end
        chk("b_ovf", ovf_o, 0);
        pop_all(4);

        // overflow, clear, and set-beats-clear
        nn_i = 6'd3;
        send(8'hA1); send(8'hA2); send(8'hA3);
        h_v_i = 1'b1; h_i = 8'hEE;
        @(negedge clk);
        h_v_i = 1'b0;
        chk("c_ovf_set", ovf_o, 1);
        chk("c_data_kept", out_o, 8'hA1);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("c_ovf_clr", ovf_o, 0);
        h_v_i = 1'b1; clr_i = 1'b1;
        @(negedge clk);
        h_v_i = 1'b0; clr_i = 1'b0;
        chk("c_set_wins", ovf_o, 1);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("c_ovf_clr2", ovf_o, 0);
        exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3;
        pop_all(3);

        // final pop coincident with a new first byte
        nn_i = 6'd2;
        send(8'h11); send(8'h22);
        rd_i = 1'b1;
        chk("d_b0", out_o, 8'h11);
        @(negedge clk);
        chk("d_b1", out_o, 8'h22);
`ifdef HASH_OUT_BUF_CRC_EN
        @(negedge clk);
        chk("d_crc", out_o, crc_ref(crc_ref(8'h00, 8'h11), 8'h22));
`else
        chk("d_last", last_o, 1);
`endif
        h_v_i = 1'b1; h_i = 8'hAA;
        @(negedge clk);
        h_v_i = 1'b0; rd_i = 1'b0;
        chk("d_no_ovf", ovf_o, 0);
        chk("d_busy", busy_o, 1);
        chk("d_cap_v", out_v_o, 0);
        send(8'hBB);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB;
        pop_all(2);

        // length clamp with nn_i changed after the first byte
        for (int k = 0; k < 2; k++) begin
            nn_i = (k == 0) ? 6'd0 : 6'd40;
            send(8'hC0);
            nn_i = 6'd2;
            for (int i = 1; i < 32; i++) begin
                chk("e_cap_v", out_v_o, 0);
                send(8'(8'hC0 + i));
            end
            chk("e_v_rise", out_v_o, 1);
            for (int i = 0; i < 32; i++) exp_b[i] = 8'(8'hC0 + i);
            pop_all(32);
        end

        // reset mid-capture discards the record
        nn_i = 6'd4;
        send(8'h01); send(8'h02);
        chk("f_busy", busy_o, 1);
        nreset = 1'b0;
        #1;
        chk("f_rst_busy", busy_o, 0);
        chk("f_rst_v", out_v_o, 0);
        @(negedge clk);
        nreset = 1'b1;
        nn_i = 6'd1;
        send(8'h55);
        exp_b[0] = 8'h55;
        pop_all(1);

`ifdef HASH_OUT_BUF_CRC_EN
        nn_i = 6'd1;
        send(8'h01);
        rd_i = 1'b1;
        chk("g_data", out_o, 8'h01);
        chk("g_last0", last_o, 0);
        @(negedge clk);
        chk("g_crc", out_o, 8'h07);
        chk("g_last1", last_o, 1);
        @(negedge clk);
        rd_i = 1'b0;
        chk("g_idle", busy_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hash_out_buf.md
HASH_OUT_BUF -- requirements
Module: hash_out_buf

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, with all state flops on the rising edge of clk.
REQ-002 Port: clk  in  1  system clock.
REQ-003 Port: nreset  in  1  asynchronous active-low reset.
REQ-004 Port: nn_i  in  6  digest length in bytes, sampled with the first hash byte.
REQ-005 Port: h_v_i  in  1  hash byte valid, from blake2s_hash256 h_v_o.
REQ-006 Port: h_i  in  8  hash byte, from blake2s_hash256 h_o, in index order 0..nn-1.
REQ-007 Port: rd_i  in  1  host pop strobe; a byte transfers when rd_i and out_v_o are both 1.
REQ-008 Port: clr_i  in  1  synchronous clear of the overflow flag.
REQ-009 Port: out_v_o  out  1  output byte valid.
REQ-010 Port: out_o  out  8  output byte.
REQ-011 Port: last_o  out  1  current output byte is the final byte of the record.
REQ-012 Port: busy_o  out  1  high whenever the state is not IDLE.
REQ-013 Port: ovf_o  out  1  sticky flag: a hash byte was dropped.

Function
REQ-014 SHALL store hash bytes in a 32x8 register buffer, with 6-bit write and read counters.
REQ-015 SHALL clamp an effective length N of 0 or more than 32 to 32, and latch N on the first accepted byte.
REQ-016 States: IDLE, CAPTURE, DRAIN, plus CRC when the macro is enabled.
REQ-017 IDLE: on h_v_i, SHALL write h_i to buf[0], set wr_cnt=1, and go to DRAIN if N==1, else to CAPTURE.
REQ-018 CAPTURE: on h_v_i, SHALL write buf[wr_cnt] and increment wr_cnt; after the write of byte N-1, SHALL go to DRAIN.
REQ-019 CAPTURE: gaps in h_v_i SHALL be tolerated, with state held.
REQ-020 DRAIN: out_v_o=1 and out_o=buf[rd_cnt]; each pop SHALL increment rd_cnt; out_v_o SHALL assert in the cycle after the clock edge that captured the last byte.
REQ-021 DRAIN: last_o SHALL be high when rd_cnt==N-1 and the macro is disabled; it SHALL be low in DRAIN when the macro is enabled.
REQ-022 Pop of the final record byte SHALL return the block to IDLE and clear rd_cnt and wr_cnt.
REQ-023 Output data and last_o SHALL stay stable while out_v_o=1 and rd_i=0.
REQ-024 When out_v_o=0, out_o=0x00 and last_o=0; rd_i SHALL be ignored.
REQ-025 h_v_i in DRAIN or CRC, other than the final-pop cycle, SHALL drop the byte and set ovf_o on the next edge.
REQ-026 On simultaneous final pop and h_v_i, SHALL accept h_i as byte 0 of the next record (IDLE rule), with no overflow.
REQ-027 clr_i SHALL clear ovf_o; if clr_i and an overflow event occur in the same cycle, set SHALL win.
REQ-028 nn_i changes after the first byte SHALL have no effect on the current record.

Reset
REQ-029 nreset low SHALL immediately force IDLE and clear both counters, the CRC register and ovf_o, with out_v_o=0, out_o=0x00, last_o=0 and busy_o=0.
REQ-030 Buffer contents need no reset; reset mid-record SHALL discard the record, and the byte at the first edge after release SHALL be treated as byte 0.

Configuration
REQ-031 Macro HASH_OUT_BUF_CRC_EN defined SHALL append one trailer byte: CRC-8, poly 0x07, init 0x00, MSB-first, no reflection, no final XOR, over all N popped bytes.
REQ-032 With the macro defined, the CRC register SHALL update on each DRAIN pop; the final DRAIN pop SHALL go to CRC, where out_o=crc, last_o=1, and a pop returns to IDLE.
REQ-033 Without the macro, there SHALL be no CRC state or register, and the record SHALL be exactly N bytes.

Verification
REQ-034 nn_i=32, 32 back-to-back bytes 0x00..0x1F, rd_i held 1 -> out_v_o rises the cycle after byte 31; out_o reads 0x00..0x1F; last_o on 0x1F (macro off).
REQ-035 nn_i=1, h_i=0x01, macro on -> out 0x01 (last_o=0), then 0x07 (last_o=1), then IDLE.
REQ-036 nn_i=4 with one-cycle gaps in h_v_i, rd_i=0 for 5 cycles in DRAIN -> out_o holds buf[0]; no ovf_o.
REQ-037 h_v_i during DRAIN mid-record -> ovf_o=1 next cycle, byte dropped, drained data unchanged; clr_i pulse -> ovf_o=0.
REQ-038 Final pop coincident with h_v_i=0xAA -> next record starts with 0xAA and ovf_o=0; nreset low mid-CAPTURE -> busy_o=0 immediately.
